// File: rtl/gol_pkg.sv
// gol_pkg: shared definitions for the Game of Life board engine.
//   - game_state encodings driven by game_of_life_FSM
//   - engine FSM state enum and matching localparam constants
//   - default board geometry
package gol_pkg;

  // game_state encodings
  localparam logic [1:0] GS_STOP  = 2'b00;
  localparam logic [1:0] GS_PRGM  = 2'b01;
  localparam logic [1:0] GS_RUN   = 2'b10;
  localparam logic [1:0] GS_PAUSE = 2'b11;

  // Engine FSM states
  typedef enum logic [1:0] {
    ENG_IDLE   = 2'd0,
    ENG_SCAN   = 2'd1,
    ENG_COMMIT = 2'd2
  } eng_state_e;

  localparam logic [1:0] ST_IDLE   = ENG_IDLE;
  localparam logic [1:0] ST_SCAN   = ENG_SCAN;
  localparam logic [1:0] ST_COMMIT = ENG_COMMIT;

  // Default board geometry
  localparam int DEF_ROWS = 8;
  localparam int DEF_COLS = 16;

endpackage

// File: rtl/gol_neighbour_count.sv
// gol_neighbour_count: combinational count of the live neighbours of one cell.
//
// Ports:
//   i_board  in  ROWS*COLS : board, bit idx = row*COLS + col
//   i_row    in  IDX_W     : row of the cell under evaluation
//   i_col    in  IDX_W     : column of the cell under evaluation
//   o_n      out 4         : number of live cells among the 8 neighbours
//
// Build option: GOL_TORUS_EN
//   defined   -> neighbour coordinates wrap modulo ROWS / COLS (toroidal)
//   undefined -> neighbours outside the grid count as dead
module gol_neighbour_count #(
  parameter int ROWS  = 8,
  parameter int COLS  = 16,
  parameter int IDX_W = 7
) (
  input  logic [ROWS*COLS-1:0] i_board,
  input  logic [IDX_W-1:0]     i_row,
  input  logic [IDX_W-1:0]     i_col,
  output logic [3:0]           o_n
);

  int r;
  int c;

  always_comb begin
    o_n = 4'd0;
    r   = 0;
    c   = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (!(dr == 0 && dc == 0)) begin
          r = int'(i_row) + dr;
          c = int'(i_col) + dc;
`ifdef GOL_TORUS_EN
          // Offsets are only +-1, so a single wrap step is enough.
          if (r < 0) r = ROWS - 1;
          else if (r >= ROWS) r = 0;
          if (c < 0) c = COLS - 1;
          else if (c >= COLS) c = 0;
          o_n = o_n + {3'b000, i_board[r*COLS + c]};
`else
          if (r >= 0 && r < ROWS && c >= 0 && c < COLS)
            o_n = o_n + {3'b000, i_board[r*COLS + c]};
`endif
        end
      end
    end
  end

endmodule

// File: rtl/gol_board_engine.sv
// gol_board_engine: board storage plus one-generation-per-step engine.
//
// Ports:
//   clka         in  1          : system clock, rising edge
//   rst_n        in  1          : asynchronous active-low reset
//   game_state   in  2          : STOP / PRGM / RUN / PAUSE from game_of_life_FSM
//   cell_idx     in  IDX_W      : row-major cell address
//   wr_en        in  1          : program write strobe (PRGM only)
//   wr_val       in  1          : value written
//   step         in  1          : one-cycle generation request
//   board        out ROWS*COLS  : current board
//   cell_val     out 1          : board[cell_idx], 0 when out of range
//   busy         out 1          : engine not IDLE
//   gen_done     out 1          : one-cycle pulse after a commit
//   gen_count    out GEN_W      : committed generations (wraps)
//   alive_count  out IDX_W+1    : live cells on the board
//   dbg_state    out 2          : engine FSM state
//
// Build option: GOL_TORUS_EN (toroidal neighbour wrap, see gol_neighbour_count).
//
// Step handshake: step is a single-cycle request with no ready/ack. It is
// taken only when the engine is IDLE and game_state is RUN on that edge;
// any other step is dropped, never queued. busy rises on the accepting edge
// and stays high through the scan and commit cycles.
module gol_board_engine
  import gol_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  parameter int IDX_W = 7,
  parameter int GEN_W = 16
) (
  input  logic                 clka,
  input  logic                 rst_n,
  input  logic [1:0]           game_state,
  input  logic [IDX_W-1:0]     cell_idx,
  input  logic                 wr_en,
  input  logic                 wr_val,
  input  logic                 step,
  output logic [ROWS*COLS-1:0] board,
  output logic                 cell_val,
  output logic                 busy,
  output logic                 gen_done,
  output logic [GEN_W-1:0]     gen_count,
  output logic [IDX_W:0]       alive_count,
  output logic [1:0]           dbg_state
);

  localparam int               N        = ROWS * COLS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(COLS - 1);
  localparam logic [IDX_W:0]   N_CELLS  = (IDX_W + 1)'(N);

  logic [1:0]       r_state;
  logic [N-1:0]     r_board;
  logic [N-1:0]     r_nxt;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_row;
  logic [IDX_W-1:0] r_col;
  logic [IDX_W:0]   r_acc;
  logic [IDX_W:0]   r_alive;
  logic [GEN_W-1:0] r_gen;
  logic             r_gen_done;

  logic [3:0]       w_n;
  logic             w_nxt_bit;
  logic             w_idx_ok;

  // Row/column are tracked alongside ptr so no divider is needed.
  gol_neighbour_count #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .IDX_W (IDX_W)
  ) u_nc (
    .i_board (r_board),
    .i_row   (r_row),
    .i_col   (r_col),
    .o_n     (w_n)
  );

  assign w_nxt_bit = (w_n == 4'd3) | (r_board[r_ptr] & (w_n == 4'd2));
  assign w_idx_ok  = {1'b0, cell_idx} < N_CELLS;

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_board    <= '0;
      r_nxt      <= '0;
      r_ptr      <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_acc      <= '0;
      r_alive    <= '0;
      r_gen      <= '0;
      r_gen_done <= 1'b0;
    end else begin
      r_gen_done <= 1'b0;
      if (game_state == GS_STOP) begin
        // Abort any generation; the board survives, the counter does not.
        r_state <= ST_IDLE;
        r_gen   <= '0;
      end else if (game_state == GS_PRGM) begin
        r_state <= ST_IDLE;
        if (wr_en && w_idx_ok && (r_board[cell_idx] != wr_val)) begin
          r_board[cell_idx] <= wr_val;
          r_alive <= wr_val ? r_alive + (IDX_W + 1)'(1) : r_alive - (IDX_W + 1)'(1);
        end
      end else begin
        // RUN and PAUSE: a started generation always finishes.
        case (r_state)
          ST_IDLE: begin
            if (step && game_state == GS_RUN) begin
              r_state <= ST_SCAN;
              r_ptr   <= '0;
              r_row   <= '0;
              r_col   <= '0;
              r_acc   <= '0;
            end
          end
          ST_SCAN: begin
            r_nxt[r_ptr] <= w_nxt_bit;
            r_acc        <= r_acc + {{IDX_W{1'b0}}, w_nxt_bit};
            if (r_ptr == LAST_IDX) begin
              r_state <= ST_COMMIT;
            end else begin
              r_ptr <= r_ptr + IDX_W'(1);
              if (r_col == LAST_COL) begin
                r_col <= '0;
                r_row <= r_row + IDX_W'(1);
              end else begin
                r_col <= r_col + IDX_W'(1);
              end
            end
          end
          ST_COMMIT: begin
            r_board    <= r_nxt;
            r_alive    <= r_acc;
            r_gen      <= r_gen + GEN_W'(1);
            r_gen_done <= 1'b1;
            r_state    <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign board       = r_board;
  assign cell_val    = w_idx_ok ? r_board[cell_idx] : 1'b0;
  assign busy        = (r_state != ST_IDLE);
  assign gen_done    = r_gen_done;
  assign gen_count   = r_gen;
  assign alive_count = r_alive;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_gol_board_engine.sv
// Testbench for gol_board_engine: an 8x16 instance for generation behaviour
// and a 10x10 instance for out-of-range programming.
module tb_gol_board_engine;
  import gol_pkg::*;

  localparam int ROWS  = 8;
  localparam int COLS  = 16;
  localparam int IDX_W = 7;
  localparam int GEN_W = 16;
  localparam int N     = ROWS * COLS;
  localparam int W     = N + IDX_W + 1 + GEN_W;
  localparam int NB    = 100;

  // ---------------- clock / reset ----------------
  logic clka;
  logic rst_n;
  initial clka = 1'b0;
  always #5 clka = ~clka;

  // ---------------- DUT A (8x16) ----------------
  logic [1:0]       game_state;
  logic [IDX_W-1:0] cell_idx;
  logic             wr_en, wr_val, step;
  logic [N-1:0]     board;
  logic             cell_val, busy, gen_done;
  logic [GEN_W-1:0] gen_count;
  logic [IDX_W:0]   alive_count;
  logic [1:0]       dbg_state;

  gol_board_engine #(.ROWS(ROWS), .COLS(COLS), .IDX_W(IDX_W), .GEN_W(GEN_W)) u_dut (
    .clka        (clka),
    .rst_n       (rst_n),
    .game_state  (game_state),
    .cell_idx    (cell_idx),
    .wr_en       (wr_en),
    .wr_val      (wr_val),
    .step        (step),
    .board       (board),
    .cell_val    (cell_val),
    .busy        (busy),
    .gen_done    (gen_done),
    .gen_count   (gen_count),
    .alive_count (alive_count),
    .dbg_state   (dbg_state)
  );

  // ---------------- DUT B (10x10) ----------------
  logic [1:0]       game_state_b;
  logic [IDX_W-1:0] cell_idx_b;
  logic             wr_en_b, wr_val_b, step_b;
  logic [NB-1:0]    board_b;
  logic             cell_val_b, busy_b, gen_done_b;
  logic [GEN_W-1:0] gen_count_b;
  logic [IDX_W:0]   alive_count_b;
  logic [1:0]       dbg_state_b;

  gol_board_engine #(.ROWS(10), .COLS(10), .IDX_W(IDX_W), .GEN_W(GEN_W)) u_dut_b (
    .clka        (clka),
    .rst_n       (rst_n),
    .game_state  (game_state_b),
    .cell_idx    (cell_idx_b),
    .wr_en       (wr_en_b),
    .wr_val      (wr_val_b),
    .step        (step_b),
    .board       (board_b),
    .cell_val    (cell_val_b),
    .busy        (busy_b),
    .gen_done    (gen_done_b),
    .gen_count   (gen_count_b),
    .alive_count (alive_count_b),
    .dbg_state   (dbg_state_b)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] cells(input int a, input int b, input int c);
    logic [N-1:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    return v;
  endfunction

  task automatic push_exp(input logic [N-1:0] b, input int alive, input int gen);
    exp_q.push_back({b, (IDX_W + 1)'(alive), GEN_W'(gen)});
  endtask

  // Monitor: every gen_done pulse must match the oldest expected generation.
  always @(negedge clka) begin
    logic [W-1:0] e;
    if (rst_n && gen_done) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_gen_done: got gen_count %0d expected no generation", gen_count);
      end else begin
        e = exp_q.pop_front();
        check("gen_board", board, e[W-1 -: N]);
        check("gen_alive", alive_count, e[GEN_W +: IDX_W + 1]);
        check("gen_count", gen_count, e[GEN_W-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int k);
    repeat (k) @(negedge clka);
  endtask

  task automatic prgm_write(input int idx, input logic val);
    game_state = GS_PRGM;
    cell_idx   = IDX_W'(idx);
    wr_val     = val;
    wr_en      = 1'b1;
    tick(1);
    wr_en      = 1'b0;
  endtask

  task automatic prgm_write_b(input int idx, input logic val);
    game_state_b = GS_PRGM;
    cell_idx_b   = IDX_W'(idx);
    wr_val_b     = val;
    wr_en_b      = 1'b1;
    tick(1);
    wr_en_b      = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick(1);
    step = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 400) begin
      cyc++;
      tick(1);
    end
    if (busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle_timeout: got busy after %0d cycles expected idle", cyc);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    rst_n = 1'b0;
    game_state = GS_STOP; cell_idx = '0; wr_en = 1'b0; wr_val = 1'b0; step = 1'b0;
    game_state_b = GS_STOP; cell_idx_b = '0; wr_en_b = 1'b0; wr_val_b = 1'b0; step_b = 1'b0;
    tick(2);
    check("rst_board", board, '0);
    check("rst_gen", gen_count, 0);
    check("rst_alive", alive_count, 0);
    check("rst_busy", busy, 0);
    check("rst_gen_done", gen_done, 0);
    rst_n = 1'b1;
    tick(1);

    // Blinker
    prgm_write(52, 1'b1);
    prgm_write(53, 1'b1);
    prgm_write(54, 1'b1);
    check("prgm_alive", alive_count, 3);
    check("prgm_cell_val", cell_val, 1);
    game_state = GS_RUN;
    push_exp(cells(37, 53, 69), 3, 1);
    pulse_step();
    wait_idle(cyc);
    check("busy_cycles", cyc, N + 1);
    tick(1);
    push_exp(cells(52, 53, 54), 3, 2);
    pulse_step();
    wait_idle(cyc);
    tick(1);

    // Step during SCAN is dropped
    push_exp(cells(37, 53, 69), 3, 3);
    pulse_step();
    tick(10);
    pulse_step();
    wait_idle(cyc);
    tick(3);
    check("drop_step_busy", busy, 0);

    // Step in PAUSE ignored
    game_state = GS_PAUSE;
    pulse_step();
    tick(2);
    check("pause_step_busy", busy, 0);

    // PAUSE mid-scan completes the generation
    game_state = GS_RUN;
    push_exp(cells(52, 53, 54), 3, 4);
    pulse_step();
    tick(20);
    game_state = GS_PAUSE;
    wait_idle(cyc);
    tick(1);

    // wr_en in RUN ignored
    game_state = GS_RUN;
    cell_idx = '0; wr_val = 1'b1; wr_en = 1'b1;
    tick(1);
    wr_en = 1'b0;
    check("run_wr_board", board, cells(52, 53, 54));
    check("run_wr_cell_val", cell_val, 0);
    check("run_wr_alive", alive_count, 3);

    // Abort with STOP 50 cycles into a scan
    pulse_step();
    tick(50);
    game_state = GS_STOP;
    tick(1);
    check("abort_busy", busy, 0);
    check("abort_state", dbg_state, ST_IDLE);
    check("abort_board", board, cells(52, 53, 54));
    check("abort_gen", gen_count, 0);
    check("abort_alive", alive_count, 3);
    tick(140);

    // Edge handling
    prgm_write(52, 1'b0);
    prgm_write(53, 1'b0);
    prgm_write(54, 1'b0);
    check("clear_alive", alive_count, 0);
    prgm_write(0, 1'b1);
    prgm_write(16, 1'b1);
    prgm_write(32, 1'b1);
    check("edge_prgm_alive", alive_count, 3);
    game_state = GS_RUN;
`ifdef GOL_TORUS_EN
    push_exp(cells(16, 17, 31), 3, 1);
`else
    push_exp(cells(16, 17, -1), 2, 1);
`endif
    pulse_step();
    wait_idle(cyc);
    tick(1);

    // Asynchronous reset mid-scan
    pulse_step();
    tick(30);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_board", board, '0);
    check("areset_gen", gen_count, 0);
    check("areset_alive", alive_count, 0);
    check("areset_busy", busy, 0);
    tick(1);
    game_state = GS_STOP;
    rst_n = 1'b1;
    tick(1);

    // Programming on the 10x10 board
    prgm_write_b(99, 1'b1);
    check("b_cell_val_99", cell_val_b, 1);
    check("b_alive_99", alive_count_b, 1);
    prgm_write_b(100, 1'b1);
    check("b_cell_val_100", cell_val_b, 0);
    check("b_alive_100", alive_count_b, 1);
    check("b_board_100", board_b, {1'b1, 99'b0});
    prgm_write_b(99, 1'b1);
    check("b_alive_rewrite", alive_count_b, 1);
    prgm_write_b(99, 1'b0);
    check("b_alive_clear", alive_count_b, 0);

    tick(5);
    check("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1000000");
    $fatal(1, "watchdog");
  end

endmodule
